// File: rtl/pixel_writeback_pkg.sv
// pixel_writeback shared types, widths and state encodings.
// Image geometry defaults and the write-back FIFO entry layout.
package pixel_writeback_pkg;

   localparam int IMAGE_WIDTH_DEF  = 320;
   localparam int IMAGE_HEIGHT_DEF = 240;
   localparam int PIXEL_W          = 12;
   localparam int ROW_W            = 8;
   localparam int COL_W            = 9;
   localparam int ADDR_W           = 17;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [PIXEL_W-1:0] data;
   } wb_entry_t;

   function automatic logic [ADDR_W-1:0] lin_addr(
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col,
      input int               width
   );
      return ADDR_W'(row) * ADDR_W'(width) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/pixel_writeback_if.sv
// pixel_writeback bus: masked pixel input handshake plus frame RAM port.
// slave = the write-back block, master = whoever drives pixels / models RAM.
interface pixel_writeback_if;
   import pixel_writeback_pkg::*;

   logic [PIXEL_W-1:0] pixel_in;
   logic [ROW_W-1:0]   pix_row;
   logic [COL_W-1:0]   pix_col;
   logic               pixel_valid;
   logic               pixel_ready;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_addr;
   logic [PIXEL_W-1:0] ram_data;
   logic               ram_ready;
   logic               frame_done;
   logic               order_err;

   modport slave (
      input  pixel_in, pix_row, pix_col, pixel_valid, ram_ready,
      output pixel_ready, ram_we, ram_addr, ram_data,
      output frame_done, order_err
   );

   modport master (
      output pixel_in, pix_row, pix_col, pixel_valid, ram_ready,
      input  pixel_ready, ram_we, ram_addr, ram_data,
      input  frame_done, order_err
   );

endinterface

// File: rtl/pixel_writeback_fifo.sv
// pixel_fifo: synchronous FIFO, registered output (no fall-through).
// Pointers carry one wrap bit so full/empty need no separate counter.
module pixel_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW:0]      wr_q, wr_d;
   logic [PW:0]      rd_q, rd_d;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PW] != rd_q[PW]) &&
                  (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign dout  = mem_q[rd_q[PW-1:0]];

   // Next storage and pointer values; overflow/underflow requests ignored.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && !full) begin
         mem_d[wr_q[PW-1:0]] = din;
         wr_d = wr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_d = rd_q + 1'b1;
      end
   end

   // Pointers reset to empty; storage contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pixel_writeback.sv
// pixel_writeback: buffers masked pixels and writes them to the frame RAM.
// Optional raster-order checker: define PIXEL_WRITEBACK_ORDER_CHECK_EN.
module pixel_writeback
   import pixel_writeback_pkg::*;
#(
   parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
   parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
   parameter int FIFO_DEPTH   = 8
) (
   input logic             Clock,
   input logic             Resetn,
   pixel_writeback_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR =
      ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

   logic [1:0] state_q, state_d;
   logic       rdy_q, rdy_d;
   wb_entry_t  in_e, head_e;
   logic       push, pop, full, empty;
   logic       accept, in_range, is_origin;

   // Ready is held low for one cycle out of reset, then tracks FIFO space.
   assign bus.pixel_ready = rdy_q && !full;
   assign accept    = bus.pixel_valid && bus.pixel_ready;
   assign in_range  = (int'(bus.pix_row) < IMAGE_HEIGHT) &&
                      (int'(bus.pix_col) < IMAGE_WIDTH);
   assign is_origin = (bus.pix_row == '0) && (bus.pix_col == '0);
   assign in_e.addr = lin_addr(bus.pix_row, bus.pix_col, IMAGE_WIDTH);
   assign in_e.data = bus.pixel_in;

   assign pop          = !empty && bus.ram_ready;
   assign bus.ram_we   = !empty;
   assign bus.ram_addr = empty ? '0 : head_e.addr;
   assign bus.ram_data = empty ? '0 : head_e.data;
   assign bus.frame_done = (state_q == ST_DONE);

   pixel_fifo #(
      .WIDTH ($bits(wb_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clock),
      .rst_n (Resetn),
      .push  (push),
      .din   (in_e),
      .pop   (pop),
      .dout  (head_e),
      .full  (full),
      .empty (empty)
   );

   // Frame FSM: wait for the origin pixel, stream, pulse done on last pop.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      rdy_d   = 1'b1;
      case (state_q)
         ST_STREAM: begin
            push = accept && in_range;
            if (pop && head_e.addr == LAST_ADDR) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            push    = accept && is_origin;
            state_d = push ? ST_STREAM : ST_IDLE;
         end
      endcase
   end

   // State and ready-enable registers.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
      end
   end

`ifdef PIXEL_WRITEBACK_ORDER_CHECK_EN
   logic              err_q, err_d;
   logic [ADDR_W-1:0] exp_q, exp_d;

   assign bus.order_err = err_q;

   // Expect each streamed pixel to follow the previously pushed one.
   always_comb begin
      err_d = err_q;
      exp_d = exp_q;
      if (push) begin
         exp_d = in_e.addr + 1'b1;
         if (state_q == ST_STREAM && in_e.addr != exp_q) begin
            err_d = 1'b1;
         end
      end
   end

   // Sticky error flag and expected-address register.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         err_q <= 1'b0;
         exp_q <= '0;
      end else begin
         err_q <= err_d;
         exp_q <= exp_d;
      end
   end
`else
   assign bus.order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_writeback.sv
// tb_pixel_writeback: scoreboard bench for pixel_writeback.
// Expected RAM writes are queued on acceptance and checked on each RAM handshake.
module tb_pixel_writeback;
   import pixel_writeback_pkg::*;

   localparam int W    = 320;
   localparam int H    = 240;
   localparam int LAST = W * H - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pixel_writeback_if bus();

   pixel_writeback #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .FIFO_DEPTH   (8)
   ) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [28:0] exp_q[$];
   logic [28:0] got_e, want_e;
   int wr_count = 0;
   int fd_count = 0;
   bit prev_last = 0;

   // RAM-side monitor: every handshake is compared with the scoreboard head.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         prev_last = 0;
      end else begin
         if (bus.frame_done === 1'b1 || prev_last) begin
            checks++;
            if (bus.frame_done !== prev_last) begin
               errors++;
               $display("FAIL frame_done got %b want %b", bus.frame_done, prev_last);
            end
         end
         if (bus.frame_done === 1'b1) fd_count++;
         prev_last = 0;
         if (bus.ram_we === 1'b1 && bus.ram_ready === 1'b1) begin
            wr_count++;
            checks++;
            got_e = {bus.ram_addr, bus.ram_data};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ram_write unexpected addr %0d data %h",
                        bus.ram_addr, bus.ram_data);
            end else begin
               want_e = exp_q.pop_front();
               if (got_e !== want_e) begin
                  errors++;
                  $display("FAIL ram_write got addr %0d data %h want addr %0d data %h",
                           got_e[28:12], got_e[11:0], want_e[28:12], want_e[11:0]);
               end
            end
            prev_last = (bus.ram_addr == 17'(LAST));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.pixel_valid = 1'b0;
      bus.ram_ready = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send_pixel(input int row, input int col,
                             input logic [11:0] d, input bit wr);
      bit ok = 0;
      bus.pixel_valid = 1'b1;
      bus.pix_row = ROW_W'(row);
      bus.pix_col = COL_W'(col);
      bus.pixel_in = d;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (bus.pixel_ready === 1'b1) ok = 1;
         step();
      end
      bus.pixel_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout row %0d col %0d got no ready want ready", row, col);
      end else if (wr) begin
         exp_q.push_back({17'(row * W + col), d});
      end
   endtask

   task automatic drain();
      bit done = 0;
      bus.ram_ready = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.ram_we === 1'b0) done = 1;
      end
      step();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain got %0d pending ram_we %b want 0 pending",
                  exp_q.size(), bus.ram_we);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.pixel_valid = 1'b0;
      bus.ram_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.pixel_ready, bus.ram_we, bus.ram_addr, bus.ram_data,
           bus.frame_done, bus.order_err} !== 33'b0) begin
         errors++;
         $display("FAIL reset_values got rdy %b we %b addr %h data %h fd %b oe %b want all 0",
                  bus.pixel_ready, bus.ram_we, bus.ram_addr, bus.ram_data,
                  bus.frame_done, bus.order_err);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.pixel_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_reset got %b want 0", bus.pixel_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.pixel_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 1", bus.pixel_ready);
      end
      step();
   endtask

   task automatic test_idle_drop();
      do_reset();
      send_pixel(5, 7, 12'h111, 0);
      send_pixel(5, 8, 12'h222, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ram_we !== 1'b0) begin
         errors++;
         $display("FAIL idle_drop got ram_we %b want 0", bus.ram_we);
      end
      step();
      send_pixel(0, 0, 12'h333, 1);
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.ram_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_pixel(0, i, 12'(i * 3 + 1), 1);
      @(negedge clk);
      checks++;
      if ({bus.pixel_ready, bus.ram_we, bus.ram_addr} !== {2'b01, 17'd0}) begin
         errors++;
         $display("FAIL full_stall got rdy %b we %b addr %0d want rdy 0 we 1 addr 0",
                  bus.pixel_ready, bus.ram_we, bus.ram_addr);
      end
      step();
      @(negedge clk);
      checks++;
      if ({bus.ram_addr, bus.ram_data} !== {17'd0, 12'd1}) begin
         errors++;
         $display("FAIL hold_stable got addr %0d data %h want addr 0 data 001",
                  bus.ram_addr, bus.ram_data);
      end
      step();
      bus.ram_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.pixel_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_pop got %b want 0", bus.pixel_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.pixel_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_pop got %b want 1", bus.pixel_ready);
      end
      step();
      drain();
   endtask

   task automatic test_out_of_range();
      int w0;
      do_reset();
      w0 = wr_count;
      send_pixel(0, 0, 12'hA00, 1);
      send_pixel(240, 3, 12'hA01, 0);
      send_pixel(1, 320, 12'hA02, 0);
      send_pixel(0, 1, 12'hA03, 1);
      drain();
      checks++;
      if (wr_count - w0 !== 2) begin
         errors++;
         $display("FAIL out_of_range got %0d writes want 2", wr_count - w0);
      end
   endtask

   task automatic test_order_check();
      logic want;
`ifdef PIXEL_WRITEBACK_ORDER_CHECK_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      do_reset();
      send_pixel(0, 0, 12'h010, 1);
      send_pixel(0, 1, 12'h011, 1);
      @(negedge clk);
      checks++;
      if (bus.order_err !== 1'b0) begin
         errors++;
         $display("FAIL order_ok got %b want 0", bus.order_err);
      end
      step();
      send_pixel(0, 3, 12'h013, 1);
      @(negedge clk);
      checks++;
      if (bus.order_err !== want) begin
         errors++;
         $display("FAIL order_err got %b want %b", bus.order_err, want);
      end
      repeat (3) step();
      @(negedge clk);
      checks++;
      if (bus.order_err !== want) begin
         errors++;
         $display("FAIL order_sticky got %b want %b", bus.order_err, want);
      end
      step();
      drain();
   endtask

   task automatic test_mid_reset();
      int w0;
      do_reset();
      bus.ram_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_pixel(0, i, 12'(12'h500 + i), 1);
      @(negedge clk);
      checks++;
      if (bus.ram_we !== 1'b1) begin
         errors++;
         $display("FAIL mid_fill got ram_we %b want 1", bus.ram_we);
      end
      step();
      rst_n = 1'b0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.ram_we, bus.ram_addr, bus.frame_done} !== 19'b0) begin
         errors++;
         $display("FAIL mid_reset got we %b addr %0d fd %b want all 0",
                  bus.ram_we, bus.ram_addr, bus.frame_done);
      end
      step();
      bus.ram_ready = 1'b1;
      w0 = wr_count;
      send_pixel(0, 5, 12'h605, 0);
      send_pixel(0, 0, 12'h600, 1);
      drain();
      checks++;
      if (wr_count - w0 !== 1) begin
         errors++;
         $display("FAIL restart got %0d writes want 1", wr_count - w0);
      end
   endtask

   task automatic test_full_frame();
      int w0;
      do_reset();
      fd_count = 0;
      w0 = wr_count;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send_pixel(r, c, 12'($urandom_range(0, 4095)), 1);
      drain();
      checks++;
      if (wr_count - w0 !== W * H) begin
         errors++;
         $display("FAIL frame_writes got %0d want %0d", wr_count - w0, W * H);
      end
      checks++;
      if (fd_count !== 1) begin
         errors++;
         $display("FAIL frame_done_count got %0d want 1", fd_count);
      end
      send_pixel(0, 5, 12'h777, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ram_we !== 1'b0) begin
         errors++;
         $display("FAIL back_to_idle got ram_we %b want 0", bus.ram_we);
      end
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.pixel_valid = 1'b0;
      bus.pixel_in = '0;
      bus.pix_row = '0;
      bus.pix_col = '0;
      bus.ram_ready = 1'b1;
      test_reset();
      test_idle_drop();
      test_backpressure();
      test_out_of_range();
      test_order_check();
      test_mid_reset();
      test_full_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_writeback.md
# pixel_writeback

Return-path endpoint of the image masking accelerator. Accepts the masked pixel stream (12-bit pixel plus row/col address) from the image masking module and writes it into the output frame RAM read by the CPU. Buffers the stream in a small FIFO so RAM back-pressure never drops pixels, and signals completion of each frame.

## Interface

- `IMAGE_WIDTH`, 320, pixels per row
- `IMAGE_HEIGHT`, 240, rows per frame
- `FIFO_DEPTH`, 8, entries in the internal buffer (power of two, ≥ 2)
- `Clock` input 1: single clock; all logic on its rising edge
- `Resetn` input 1: reset, synchronous, active-low
- `pixel_in` input 12: masked pixel from the image masking module
- `pix_row` input 8: row address of `pixel_in`
- `pix_col` input 9: column address of `pixel_in`
- `pixel_valid` input 1: `pixel_in`/`pix_row`/`pix_col` are valid this cycle
- `pixel_ready` output 1: block can accept a pixel this cycle
- `ram_we` output 1: write strobe to the frame RAM
- `ram_addr` output 17: linear frame RAM address
- `ram_data` output 12: pixel written to the frame RAM
- `ram_ready` input 1: frame RAM accepts the write this cycle
- `frame_done` output 1: one-cycle pulse when the last pixel of a frame is committed to RAM
- `order_err` output 1: sticky raster-order error flag (see Configuration)

## Operation

- Input handshake: a pixel is accepted on a cycle where `pixel_valid && pixel_ready`. `pixel_ready = !fifo_full`, registered-state-derived only; it never depends on `pixel_valid`.
- On acceptance: compute `addr = pix_row*IMAGE_WIDTH + pix_col` (17-bit, unsigned) and push {addr, pixel} into the FIFO.
- Accepted pixels with `pix_row >= IMAGE_HEIGHT` or `pix_col >= IMAGE_WIDTH` are dropped (not pushed, still handshaken).
- Output side: `ram_we` = FIFO not empty; `ram_addr`/`ram_data` = FIFO head. Head pops when `ram_we && ram_ready`. Address/data hold stable while `ram_we && !ram_ready`.
- FIFO: simultaneous push and pop when full is not allowed (ready is low). Simultaneous push and pop when non-empty keeps the count unchanged. Empty-FIFO push is visible at the output the next cycle; there is no fall-through.
- State machine:
  - IDLE: accepted pixels not at (0,0) are dropped. An accepted (0,0) pixel is pushed, and the state goes to STREAM.
  - STREAM: all in-range pixels are pushed. When the entry with addr `IMAGE_WIDTH*IMAGE_HEIGHT-1` pops, the state goes to DONE.
  - DONE: `frame_done=1` for this single cycle. Go to IDLE; any pixel accepted in this cycle is treated with IDLE rules.
- Reset mid-frame: FIFO is emptied, any in-flight RAM write is abandoned, and the state returns to IDLE.

## Timing

- Reset values: `pixel_ready=0` during reset, 1 the first cycle after; `ram_we=0`, `ram_addr=0`, `ram_data=0`, `frame_done=0`, `order_err=0`.
- Latency: pixel accepted at edge N produces `ram_we=1` with its address in cycle N+1, provided the FIFO was empty.
- Throughput: 1 pixel/cycle sustained while `ram_ready=1`.
- `frame_done` rises the cycle after the last pixel's RAM handshake.

## Configuration

- `PIXEL_WRITEBACK_ORDER_CHECK_EN`
  - Defined: in STREAM, each pushed pixel's addr is compared to the expected next addr (previous+1). A mismatch sets `order_err`, which stays set until reset. The pixel is still written.
  - Undefined: no comparator, and `order_err` is tied to 0.

## Structure

- `IMAGE_WIDTH`/`IMAGE_HEIGHT` defaults, `PIXEL_W=12`, `ROW_W=8`, `COL_W=9`, `ADDR_W=17` and state encodings go in the shared `utils.v` defines.
- One sub-module: `pixel_fifo` (synchronous FIFO, parameterised width/depth, full/empty flags).

## Test plan

- Reset, then stream a full 320×240 frame starting at (0,0) with `ram_ready=1` → 76800 writes, addresses 0..76799 in order. `frame_done` pulses once, the cycle after the write to addr 76799.
- Pixels at (5,7),(5,8) while in IDLE, then (0,0) → first `ram_we` has `ram_addr=0`; the earlier pixels are never written.
- Hold `ram_ready=0` and push 8 pixels → `pixel_ready` drops after the 8th. Release → the 8 writes appear in order, and `pixel_ready` returns the cycle after the first pop.
- Pixel at row 240 or col 320 during STREAM → no RAM write; the following valid pixel is written normally.
- With `PIXEL_WRITEBACK_ORDER_CHECK_EN` defined: (0,0),(0,1),(0,3) → `order_err=1` from the cycle after (0,3) is accepted, and it stays 1. Undefined → `order_err` stays 0.
- Assert `Resetn=0` for one cycle mid-frame with the FIFO holding 4 entries → next cycle `ram_we=0`, FIFO empty, state IDLE. A later (0,0) restarts at `ram_addr=0`.
